ps2_scancode_rx: RTL and testbench

Receives the serial PS/2 keyboard stream and recovers scan-code bytes from it. It decodes make/break/extended prefixes and presents the most recent make code on an 8-bit `keyval` bus. This is the stage directly upstream of the hex-display driver, whose `keyval[7:0]` input it feeds. It runs entirely in the `CLOCK_50` domain and oversamples the asynchronous PS/2 clock and data lines.

---
 rtl/ps2_scancode_rx.sv | 217 +++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scan-code receiver.
// Oversamples the asynchronous PS/2 clock/data pins in the CLOCK_50 domain,
// frames 11-bit PS/2 words (start, 8 data LSB-first, odd parity, stop),
// abandons stalled frames after TIMEOUT_CYCLES, and decodes E0/F0 prefixes
// into the most recent make code on keyval for the hex-display stage.
//
// Handshake note: there is no valid/ready pair on the output side. keyval,
// extended and key_down are level outputs held between updates and may be
// sampled at any time; code_valid and frame_err are single-cycle event pulses
// with no back-pressure.
module ps2_scancode_rx #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] keyval,
   output logic       extended,
   output logic       key_down,
   output logic       code_valid,
   output logic       frame_err,
   output logic [1:0] dbg_state
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   // Input conditioning flops
   logic clk_s1_q, clk_s2_q, clk_prev_q;
   logic dat_s1_q, dat_s2_q;

   // Frame receiver state
   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [CW-1:0] to_cnt_q, to_cnt_d;
   logic          byte_done_q, byte_done_d;
   logic [7:0]    byte_q, byte_d;
   logic          frame_err_q, frame_err_d;

   // Decoder state
   logic          ext_pend_q, ext_pend_d;
   logic          brk_pend_q, brk_pend_d;
   logic [7:0]    keyval_q, keyval_d;
   logic          extended_q, extended_d;
   logic          key_down_q, key_down_d;
   logic          code_valid_q, code_valid_d;

   logic fall;
   logic bit_in;
   logic timeout;
   logic is_status;

   assign fall      = clk_prev_q & ~clk_s2_q;
   assign bit_in    = dat_s2_q;
   assign timeout   = (state_q != ST_IDLE) && (to_cnt_q == TO_MAX);
   assign is_status = (byte_q == 8'hAA) || (byte_q == 8'hFA) || (byte_q == 8'hEE);

   // Two-stage synchronizers plus previous-clock register; all preset to 1 (idle)
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= PS2_CLK;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= PS2_DAT;
         dat_s2_q   <= dat_s1_q;
      end
   end

   // Frame FSM next-state: start/data/parity/stop sequencing and timeout abort
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      byte_done_d = 1'b0;
      byte_d      = byte_q;
      frame_err_d = 1'b0;
      if (timeout) begin
         state_d     = ST_IDLE;
         frame_err_d = 1'b1;
      end else if (fall) begin
         case (state_q)
            ST_IDLE: begin
               // A high bit while idle is treated as noise and ignored
               if (!bit_in) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            ST_DATA: begin
               shift_d   = {bit_in, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               parity_d = bit_in;
               state_d  = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (bit_in && (^{shift_q, parity_q})) begin
                  byte_done_d = 1'b1;
                  byte_d      = shift_q;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Inactivity counter: cleared on each PS/2 edge and while idle, saturating
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (fall || (state_q == ST_IDLE)) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != TO_MAX) begin
         to_cnt_d = to_cnt_q + CW'(1);
      end
   end

   // Frame receiver registers
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         parity_q    <= 1'b0;
         to_cnt_q    <= '0;
         byte_done_q <= 1'b0;
         byte_q      <= 8'h00;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         to_cnt_q    <= to_cnt_d;
         byte_done_q <= byte_done_d;
         byte_q      <= byte_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Scan-code decoder: prefix flags, break matching, status filtering, make codes
   always_comb begin
      ext_pend_d   = ext_pend_q;
      brk_pend_d   = brk_pend_q;
      keyval_d     = keyval_q;
      extended_d   = extended_q;
      key_down_d   = key_down_q;
      code_valid_d = 1'b0;
      if (byte_done_q) begin
         if (byte_q == 8'hE0) begin
            ext_pend_d = 1'b1;
         end else if (byte_q == 8'hF0) begin
            brk_pend_d = 1'b1;
         end else if (brk_pend_q) begin
            // Release only clears key_down if it names the key currently shown
            if ({ext_pend_q, byte_q} == {extended_q, keyval_q}) key_down_d = 1'b0;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
         end else if (!(is_status && !ext_pend_q)) begin
            keyval_d     = byte_q;
            extended_d   = ext_pend_q;
            key_down_d   = 1'b1;
            code_valid_d = 1'b1;
            ext_pend_d   = 1'b0;
            brk_pend_d   = 1'b0;
         end
      end
   end

   // Decoder registers
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         ext_pend_q   <= 1'b0;
         brk_pend_q   <= 1'b0;
         keyval_q     <= 8'h00;
         extended_q   <= 1'b0;
         key_down_q   <= 1'b0;
         code_valid_q <= 1'b0;
      end else begin
         ext_pend_q   <= ext_pend_d;
         brk_pend_q   <= brk_pend_d;
         keyval_q     <= keyval_d;
         extended_q   <= extended_d;
         key_down_q   <= key_down_d;
         code_valid_q <= code_valid_d;
      end
   end

   assign keyval     = keyval_q;
   assign extended   = extended_q;
   assign key_down   = key_down_q;
   assign code_valid = code_valid_q;
   assign frame_err  = frame_err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed PS/2 frames followed by a random byte
// stream, checked against a keyboard-protocol reference model.
module tb_ps2_scancode_rx;

   localparam int TO = 1000;

   // ---------------- clock / reset ----------------
   logic clk     = 1'b0;
   logic resetn  = 1'b0;
   logic ps2_clk = 1'b1;
   logic ps2_dat = 1'b1;

   logic [7:0] keyval;
   logic       extended;
   logic       key_down;
   logic       code_valid;
   logic       frame_err;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ps2_scancode_rx #(.TIMEOUT_CYCLES(TO)) dut (
      .CLOCK_50   (clk),
      .resetn     (resetn),
      .PS2_CLK    (ps2_clk),
      .PS2_DAT    (ps2_dat),
      .keyval     (keyval),
      .extended   (extended),
      .key_down   (key_down),
      .code_valid (code_valid),
      .frame_err  (frame_err),
      .dbg_state  (dbg_state)
   );

   // ---------------- check bookkeeping ----------------
   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // ---------------- reference model ----------------
   logic [7:0] exp_q[$];
   logic [7:0] m_key  = 8'h00;
   logic       m_ext  = 1'b0;
   logic       m_down = 1'b0;
   logic       m_ep   = 1'b0;
   logic       m_bp   = 1'b0;

   task automatic model_reset();
      m_key = 8'h00; m_ext = 1'b0; m_down = 1'b0; m_ep = 1'b0; m_bp = 1'b0;
      exp_q.delete();
   endtask

   // Apply one correctly received byte to the keyboard-state model
   task automatic model_byte(input logic [7:0] b, output logic make);
      make = 1'b0;
      if (b == 8'hE0) m_ep = 1'b1;
      else if (b == 8'hF0) m_bp = 1'b1;
      else if (m_bp) begin
         if (b == m_key && m_ep == m_ext) m_down = 1'b0;
         m_ep = 1'b0;
         m_bp = 1'b0;
      end else if (!m_ep && (b inside {8'hAA, 8'hFA, 8'hEE})) make = 1'b0;
      else begin
         m_key = b; m_ext = m_ep; m_down = 1'b1; m_ep = 1'b0;
         make = 1'b1;
         exp_q.push_back(b);
      end
   endtask

   // ---------------- output monitor / scoreboard ----------------
   int          cv_n = 0;
   int          fe_n = 0;
   int unsigned cv_cyc = 0;
   int unsigned fe_cyc = 0;
   logic [7:0]  exp_v;

   always @(negedge clk) begin
      if (code_valid) begin
         cv_n++;
         cv_cyc = cyc;
         if (exp_q.size() > 0) exp_v = exp_q.pop_front();
         else exp_v = 8'hxx;
         chk("cv_keyval", {24'd0, keyval}, {24'd0, exp_v});
      end
      if (frame_err) begin
         fe_n++;
         fe_cyc = cyc;
      end
   end

   // ---------------- driver tasks ----------------
   int unsigned last_fall = 0;

   task automatic send_bit(input logic b, input int h);
      @(negedge clk);
      ps2_dat = b;
      repeat (h) @(negedge clk);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      repeat (h) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic do_frame(input logic [7:0] b, input logic par_bad, input logic stop_bit,
                           input int h);
      logic [10:0] bits;
      logic        good;
      logic        make;
      int unsigned stop_cyc;
      good = !par_bad && stop_bit;
      make = 1'b0;
      if (good) model_byte(b, make);
      bits = {stop_bit, (~^b) ^ par_bad, b, 1'b0};
      cv_n = 0;
      fe_n = 0;
      for (int i = 0; i < 11; i++) send_bit(bits[i], h);
      stop_cyc = last_fall;
      repeat (6) @(negedge clk);
      #1;
      chk("cv_count", cv_n, {31'd0, make});
      chk("fe_count", fe_n, {31'd0, !good});
      if (make) chk("cv_latency", cv_cyc - stop_cyc, 4);
      if (!good) chk("fe_latency", fe_cyc - stop_cyc, 3);
      chk("keyval", {24'd0, keyval}, {24'd0, m_key});
      chk("extended", {31'd0, extended}, {31'd0, m_ext});
      chk("key_down", {31'd0, key_down}, {31'd0, m_down});
      chk("state_idle", {30'd0, dbg_state}, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_keyval"}, {24'd0, keyval}, 0);
      chk({tag, "_extended"}, {31'd0, extended}, 0);
      chk({tag, "_key_down"}, {31'd0, key_down}, 0);
      chk({tag, "_code_valid"}, {31'd0, code_valid}, 0);
      chk({tag, "_frame_err"}, {31'd0, frame_err}, 0);
      chk({tag, "_state"}, {30'd0, dbg_state}, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0]  b;
      logic        pb, sb;
      int          r;
      int unsigned t0;
      logic [7:0]  part;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk_all_zero("reset");
      resetn = 1'b1;
      repeat (5) @(negedge clk);

      // Make, typematic repeat, break
      do_frame(8'h1C, 1'b0, 1'b1, 20);
      do_frame(8'h1C, 1'b0, 1'b1, 20);
      do_frame(8'hF0, 1'b0, 1'b1, 20);
      do_frame(8'h1C, 1'b0, 1'b1, 20);

      // Extended make, non-matching break, matching extended break
      do_frame(8'hE0, 1'b0, 1'b1, 15);
      do_frame(8'h75, 1'b0, 1'b1, 15);
      do_frame(8'hF0, 1'b0, 1'b1, 15);
      do_frame(8'h75, 1'b0, 1'b1, 15);
      do_frame(8'hE0, 1'b0, 1'b1, 15);
      do_frame(8'hF0, 1'b0, 1'b1, 15);
      do_frame(8'h75, 1'b0, 1'b1, 15);

      // Status byte ignored, bad parity, bad stop
      do_frame(8'h1C, 1'b0, 1'b1, 12);
      do_frame(8'hAA, 1'b0, 1'b1, 12);
      do_frame(8'h1C, 1'b1, 1'b1, 12);
      do_frame(8'h1C, 1'b0, 1'b0, 12);

      // Timeout: start bit plus 4 data bits, then the line stalls high
      cv_n = 0;
      fe_n = 0;
      part = 8'h35;
      send_bit(1'b0, 10);
      for (int i = 0; i < 4; i++) send_bit(part[i], 10);
      t0 = last_fall;
      for (int i = 0; i < TO + 50 && fe_n == 0; i++) @(negedge clk);
      #1;
      chk("to_fe_count", fe_n, 1);
      chk("to_fe_latency", fe_cyc - t0, TO + 3);
      chk("to_state_idle", {30'd0, dbg_state}, 0);
      chk("to_cv_count", cv_n, 0);
      do_frame(8'h2A, 1'b0, 1'b1, 20);

      // Reset in the middle of a frame
      send_bit(1'b0, 10);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 10);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk_all_zero("midreset");
      model_reset();
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      do_frame(8'h16, 1'b0, 1'b1, 20);

      // Random byte stream with occasional corrupted frames
      for (int n = 0; n < 24; n++) begin
         r = $urandom_range(0, 99);
         if (r < 20) b = 8'hE0;
         else if (r < 40) b = 8'hF0;
         else if (r < 48) begin
            case ($urandom_range(0, 2))
               0: b = 8'hAA;
               1: b = 8'hFA;
               default: b = 8'hEE;
            endcase
         end else begin
            case ($urandom_range(0, 3))
               0: b = 8'h1C;
               1: b = 8'h75;
               2: b = 8'h2A;
               default: b = 8'($urandom_range(0, 255));
            endcase
         end
         pb = 1'b0;
         sb = 1'b1;
         if ($urandom_range(0, 99) < 15) begin
            if ($urandom_range(0, 1) == 0) pb = 1'b1;
            else sb = 1'b0;
         end
         do_frame(b, pb, sb, $urandom_range(8, 30));
      end

      chk("exp_q_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
